// File: rtl/seg7_pkg.sv
// Shared segment and anode constants for the 7-segment scan driver.
// Segment vectors are active-low, bit 0 = a .. bit 6 = g.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] digit_t;

  localparam seg_t SEG_0    = 7'b1000000;
  localparam seg_t SEG_1    = 7'b1111001;
  localparam seg_t SEG_2    = 7'b0100100;
  localparam seg_t SEG_3    = 7'b0110000;
  localparam seg_t SEG_4    = 7'b0011001;
  localparam seg_t SEG_5    = 7'b0010010;
  localparam seg_t SEG_6    = 7'b0000010;
  localparam seg_t SEG_7    = 7'b1111000;
  localparam seg_t SEG_8    = 7'b0000000;
  localparam seg_t SEG_9    = 7'b0010000;
  localparam seg_t SEG_DASH = 7'b0111111;
  localparam seg_t SEG_OFF  = 7'b1111111;

  localparam digit_t DIGIT_OFF = 4'b1111;

  // Active-low one-hot anode enable for a slot index.
  function automatic digit_t digit_enable(input logic [1:0] idx);
    return ~(digit_t'(1) << idx);
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
// Non-decimal codes 10..15 render as a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment scan driver with frame-coherent capture.
// Optional leading-zero suppression: define SEG7_LEADING_ZERO_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bcd_in,
  input  logic        blank,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0] prescaler_reg;
  logic [1:0]    index_reg;
  logic [1:0]    index_next;
  logic [15:0]   snapshot_reg;
  logic [15:0]   digit_src;
  logic          tick;
  logic          frame_start;
  logic [3:0]    digit_val;
  logic [6:0]    seg;
  logic          digit_dark;

  assign tick        = (prescaler_reg == PRE_LAST);
  assign index_next  = index_reg + 2'd1;
  assign frame_start = tick && (index_next == 2'd0);

  // At frame start the snapshot is being loaded this very edge, so read bcd_in directly.
  assign digit_src = frame_start ? bcd_in : snapshot_reg;
  assign digit_val = digit_src[index_next*4 +: 4];

  bcd_to_seg7 u_dec (
    .bcd (digit_val),
    .seg (seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [3:0] lead_zero;

  assign lead_zero[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
      assign lead_zero[gi] = (snapshot_reg[15:gi*4] == '0);
    end
  endgenerate

  assign digit_dark = lead_zero[index_next];
`else
  assign digit_dark = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_reg <= '0;
      index_reg     <= 2'd3;
      snapshot_reg  <= 16'h0000;
      DIGIT         <= DIGIT_OFF;
      DISPLAY       <= SEG_OFF;
    end else begin
      // >= also recovers from any out-of-range count when SCAN_DIV is not a power of two.
      if (prescaler_reg >= PRE_LAST) prescaler_reg <= '0;
      else                           prescaler_reg <= prescaler_reg + 1'b1;

      if (tick) index_reg <= index_next;
      if (frame_start) snapshot_reg <= bcd_in;

      if (blank) begin
        DIGIT   <= DIGIT_OFF;
        DISPLAY <= SEG_OFF;
      end else if (tick) begin
        if (digit_dark) begin
          DIGIT   <= DIGIT_OFF;
          DISPLAY <= SEG_OFF;
        end else begin
          DIGIT   <= digit_enable(index_next);
          DISPLAY <= seg;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver (SCAN_DIV = 4).
// Reference model reasons in edges-since-reset, slots and frames.
module tb_seg7_scan_driver;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        blank = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.SCAN_DIV(DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .bcd_in  (bcd_in),
    .blank   (blank),
    .DIGIT   (DIGIT),
    .DISPLAY (DISPLAY)
  );

  function automatic logic [6:0] ref_seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Reference model: every DIV-th edge after reset release is a slot boundary;
  // slot n (1-based) shows digit (n-1) mod 4 of the frame latched at its slot 0.
  int          e_cnt = 0;
  logic [15:0] frame_val = 16'h0000;
  logic [3:0]  exp_dig = 4'hF;
  logic [6:0]  exp_disp = 7'h7F;

  always @(posedge clk) begin : ref_model
    int e;
    int slot;
    logic [15:0] fv;
    bit dark;
    if (reset) begin
      e_cnt     <= 0;
      frame_val <= 16'h0000;
      exp_dig   <= 4'hF;
      exp_disp  <= 7'h7F;
    end else begin
      e = e_cnt + 1;
      e_cnt <= e;
      if (e % DIV == 0) begin
        slot = (e / DIV - 1) % 4;
        fv = (slot == 0) ? bcd_in : frame_val;
        if (slot == 0) frame_val <= bcd_in;
        dark = blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (slot > 0 && (fv >> (4 * slot)) == 16'h0000) dark = 1'b1;
`endif
        if (dark) begin
          exp_dig  <= 4'hF;
          exp_disp <= 7'h7F;
        end else begin
          exp_dig  <= 4'hF ^ (4'h1 << slot);
          exp_disp <= ref_seg(int'((fv >> (4 * slot)) & 16'hF));
        end
      end else if (blank) begin
        exp_dig  <= 4'hF;
        exp_disp <= 7'h7F;
      end
    end
  end

  task automatic test_reset;
    reset = 1'b1;
    bcd_in = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (DIGIT !== 4'b1111 || DISPLAY !== 7'b1111111) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %b/%b expected 1111/1111111", k, DIGIT, DISPLAY);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_scan;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({DIGIT, DISPLAY} !== {exp_dig, exp_disp}) begin
        n_bad++;
        $display("FAIL scan cyc %0d: got %b/%b expected %b/%b", k, DIGIT, DISPLAY, exp_dig, exp_disp);
      end
      if (k == 4) begin
        n_cmp++;
        if (DIGIT !== 4'b1110 || DISPLAY !== 7'b0011001) begin
          n_bad++;
          $display("FAIL first_tick: got %b/%b expected 1110/0011001", DIGIT, DISPLAY);
        end
      end
    end
  endtask

  task automatic test_tearing;
    reset = 1'b1;
    bcd_in = 16'h1234;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 9) bcd_in = 16'h5678;
      n_cmp++;
      if ({DIGIT, DISPLAY} !== {exp_dig, exp_disp}) begin
        n_bad++;
        $display("FAIL tearing cyc %0d: got %b/%b expected %b/%b", k, DIGIT, DISPLAY, exp_dig, exp_disp);
      end
    end
  endtask

  task automatic test_dash_zero;
    logic [15:0] pats [2];
    pats[0] = 16'h00A0;
    pats[1] = 16'h0000;
    for (int p = 0; p < 2; p++) begin
      reset = 1'b1;
      bcd_in = pats[p];
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        n_cmp++;
        if ({DIGIT, DISPLAY} !== {exp_dig, exp_disp}) begin
          n_bad++;
          $display("FAIL dash_zero pat %h cyc %0d: got %b/%b expected %b/%b",
                   pats[p], k, DIGIT, DISPLAY, exp_dig, exp_disp);
        end
        if (k == 8 && p == 0) begin
          n_cmp++;
          if (DIGIT !== 4'b1101 || DISPLAY !== 7'b0111111) begin
            n_bad++;
            $display("FAIL dash_slot1: got %b/%b expected 1101/0111111", DIGIT, DISPLAY);
          end
        end
      end
    end
  endtask

  task automatic test_blank;
    reset = 1'b1;
    bcd_in = 16'h9876;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({DIGIT, DISPLAY} !== {exp_dig, exp_disp}) begin
        n_bad++;
        $display("FAIL blank cyc %0d: got %b/%b expected %b/%b", k, DIGIT, DISPLAY, exp_dig, exp_disp);
      end
      if (k == 10) begin
        n_cmp++;
        if (DIGIT !== 4'b1111 || DISPLAY !== 7'b1111111) begin
          n_bad++;
          $display("FAIL blank_dark: got %b/%b expected 1111/1111111", DIGIT, DISPLAY);
        end
      end
      if (k == 9) blank = 1'b1;
      if (k == 19) blank = 1'b0;
    end
  endtask

  task automatic test_reset_mid;
    reset = 1'b1;
    bcd_in = 16'h4321;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({DIGIT, DISPLAY} !== {exp_dig, exp_disp}) begin
        n_bad++;
        $display("FAIL reset_mid cyc %0d: got %b/%b expected %b/%b", k, DIGIT, DISPLAY, exp_dig, exp_disp);
      end
      if (k == 14) begin
        n_cmp++;
        if (DIGIT !== 4'b1111 || DISPLAY !== 7'b1111111) begin
          n_bad++;
          $display("FAIL reset_mid_dark: got %b/%b expected 1111/1111111", DIGIT, DISPLAY);
        end
      end
      if (k == 18) begin
        n_cmp++;
        if (DIGIT !== 4'b1110 || DISPLAY !== 7'b1111001) begin
          n_bad++;
          $display("FAIL reset_mid_restart: got %b/%b expected 1110/1111001", DIGIT, DISPLAY);
        end
      end
      reset = (k == 13);
    end
  endtask

  task automatic test_random;
    reset = 1'b1;
    bcd_in = 16'($urandom);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 160; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({DIGIT, DISPLAY} !== {exp_dig, exp_disp}) begin
        n_bad++;
        $display("FAIL random cyc %0d: got %b/%b expected %b/%b", k, DIGIT, DISPLAY, exp_dig, exp_disp);
      end
      if ($urandom_range(7) == 0) bcd_in = 16'($urandom);
      if ($urandom_range(3) == 0) bcd_in[15:8] = 8'h00;
      blank = ($urandom_range(15) == 0);
    end
    blank = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scan();
    test_tearing();
    test_dash_zero();
    test_blank();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, meaning clk cycles per digit slot (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port bcd_in  input  16  four BCD digits; [3:0] = digit 0 (rightmost) .. [15:12] = digit 3.
REQ-005 SHALL have port blank  input  1  forces display dark while high.
REQ-006 SHALL have port DIGIT  output  4  active-low anode enables; DIGIT[0] = rightmost digit.
REQ-007 SHALL have port DISPLAY  output  7  active-low segments, DISPLAY[0]=a .. DISPLAY[6]=g.

Function
REQ-008 SHALL count prescaler 0..SCAN_DIV-1 and wrap; tick = one-cycle strobe when prescaler == SCAN_DIV-1.
REQ-009 SHALL hold 2-bit slot index; on each tick, index advances 0->1->2->3->0.
REQ-010 SHALL capture bcd_in into a 16-bit snapshot on the tick at which index wraps to 0 (frame start); no mid-frame tearing.
REQ-011 SHALL register DIGIT and DISPLAY on the tick edge: DIGIT = one-hot-low for the new index; DISPLAY = decode of the selected digit, taken from bcd_in at frame start, from snapshot otherwise.
REQ-012 SHALL hold DIGIT/DISPLAY constant between ticks; exactly one DIGIT bit low per slot, except when dark.
REQ-013 SHALL decode 0-9 to standard patterns (0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000); codes 10-15 SHALL show dash 7'b0111111.
REQ-014 SHALL drive DIGIT=4'b1111 and DISPLAY=7'b1111111 on the first edge with blank high; prescaler and index keep running; display resumes on next tick after blank falls.
REQ-015 SHALL, on prescaler wrap beyond SCAN_DIV-1 (unreachable), force prescaler to 0.

Reset
REQ-016 SHALL, on any edge with reset high, set prescaler=0, index=3, snapshot=16'h0000, DIGIT=4'b1111, DISPLAY=7'b1111111.
REQ-017 SHALL, after reset release, produce first tick SCAN_DIV cycles later, showing digit 0 from a fresh bcd_in capture.
REQ-018 SHALL, on reset asserted mid-frame, abandon the frame immediately; reset dominates blank and tick.

Configuration
REQ-019 SHALL support macro SEG7_LEADING_ZERO_BLANK_EN.
REQ-020 SHALL, with macro defined, blank digit k (k=3..1) when it and all higher digits of the frame snapshot equal 0 (DIGIT bit stays high); digit 0 never blanked.
REQ-021 SHALL, without macro, display all four digits including leading zeros.

Structure
REQ-022 SHALL place segment constants (SEG_0..SEG_9, SEG_DASH, SEG_OFF) and DIGIT_OFF in shared package/include seg7_pkg.
REQ-023 SHALL implement the decode as combinational sub-module bcd_to_seg7 (4-bit in, 7-bit active-low out).

Verification (SCAN_DIV=4)
REQ-024 reset 3 cycles, bcd_in=16'h1234 -> DIGIT=1111/DISPLAY=1111111 until first tick 4 cycles after release, then DIGIT 1110/"4", 1101/"3", 1011/"2", 0111/"1", each 4 cycles.
REQ-025 change bcd_in 16'h1234->16'h5678 during slot 1 -> slots 2,3 still show "2","1"; next frame shows "8","7","6","5".
REQ-026 bcd_in=16'h00A0 -> digit 1 shows 7'b0111111; with macro, digits 3,2 dark; without, digits 3,2 show 7'b1000000.
REQ-027 bcd_in=16'h0000 with macro -> only DIGIT=1110 ever active, showing 7'b1000000; other slots DIGIT=1111.
REQ-028 blank high for 10 cycles mid-frame -> DIGIT=1111 next edge; normal scan resumes on next tick with correct slot order.
REQ-029 reset pulsed during slot 2 -> outputs dark next edge, index restarts; first post-reset slot is digit 0.
